// File: rtl/zone_backlight_stat.sv
// zone_backlight_stat: local-dimming statistics engine.
// Tiles the active image into ZONES_H x ZONES_V zones and reduces each zone to
// one gray value (max or mean of max(R,G,B)). One write per zone is emitted.
// Optional feature macro: ZONE_IIR_EN (per-zone temporal filter, +1 cycle latency).
module zone_backlight_stat #(
  parameter int DATA_W  = 8,
  parameter int GRAY_W  = 16,
  parameter int ZONES_H = 8,
  parameter int ZONES_V = 4,
  parameter int ZW_LOG2 = 7,
  parameter int ZH_LOG2 = 7,
  parameter int ADDR_W  = 10
) (
  input  logic              I_pix_clk,
  input  logic              I_rst_n,
  input  logic              I_vs,
  input  logic              I_de,
  input  logic [DATA_W-1:0] I_data_r,
  input  logic [DATA_W-1:0] I_data_g,
  input  logic [DATA_W-1:0] I_data_b,
  input  logic              I_mode,
  output logic              O_sdbp,
  output logic              O_wr_en,
  output logic [ADDR_W-1:0] O_wr_addr,
  output logic [GRAY_W-1:0] O_wr_data,
  output logic              O_frame_err,
  output logic              O_busy
);

  localparam int SUM_W  = DATA_W + ZW_LOG2 + ZH_LOG2;
  localparam int SHIFT  = ZW_LOG2 + ZH_LOG2;
  localparam int COLS   = ZONES_H << ZW_LOG2;
  localparam int LINES  = ZONES_V << ZH_LOG2;
  localparam int CW     = $clog2(COLS + 1);
  localparam int LW     = $clog2(LINES + 1);
  localparam int ZC_W   = (ZONES_H > 1) ? $clog2(ZONES_H) : 1;
  localparam int ZR_W   = (ZONES_V > 1) ? $clog2(ZONES_V) : 1;
  localparam int NZ_W   = $clog2(ZONES_H + 1);
  localparam int NZONES = ZONES_H * ZONES_V;

  typedef enum logic [1:0] {
    S_WAIT_VS = 2'd0,
    S_FRAME   = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  // brightness of one pixel: largest colour component
  function automatic logic [DATA_W-1:0] max3(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b,
                                             input logic [DATA_W-1:0] c);
    logic [DATA_W-1:0] m;
    m    = (a > b) ? a : b;
    max3 = (m > c) ? m : c;
  endfunction

  // replicate the DATA_W value MSB-first across GRAY_W bits (0x10 -> 0x1010)
  function automatic logic [GRAY_W-1:0] widen(input logic [DATA_W-1:0] v);
    for (int i = 0; i < GRAY_W; i++) begin
      widen[GRAY_W-1-i] = v[DATA_W-1-(i % DATA_W)];
    end
  endfunction

  state_t              state_r;
  logic                busy_r, mode_r, frame_err_r;
  logic                vs_d_r, de_d_r;
  logic [CW-1:0]       col_r;
  logic [LW-1:0]       line_r;
  logic [NZ_W-1:0]     next_zc_r;
  logic                flush_r;
  logic [ZC_W-1:0]     flush_zc_r;
  logic [ZR_W-1:0]     flush_zr_r;
  logic                s1_pix_r, s1_emit_r, s1_mode_r;
  logic [DATA_W-1:0]   s1_p_r;
  logic [ZC_W-1:0]     s1_zc_r;
  logic [ZR_W-1:0]     s1_zr_r;
  logic [SUM_W-1:0]    row_buf_r [ZONES_H];
  logic                wr_en_r, sdbp_r;
  logic [ADDR_W-1:0]   wr_addr_r;
  logic [GRAY_W-1:0]   wr_data_r;

  logic                vs_rise_s, de_fall_s, in_area_s, pix_ok_s;
  logic                last_px_s, last_line_s, last_addr_s, done_s;
  logic [ZC_W-1:0]     zc_s;
  logic [ZR_W-1:0]     zr_s;
  logic [SUM_W-1:0]    acc_old_s, acc_new_s, mean_s;
  logic [DATA_W-1:0]   gray8_s;
  logic [ADDR_W-1:0]   emit_addr_s;

  assign vs_rise_s   = I_vs & ~vs_d_r;
  assign de_fall_s   = ~I_de & de_d_r;
  assign in_area_s   = (col_r < CW'(COLS)) && (line_r < LW'(LINES));
  assign pix_ok_s    = (state_r == S_FRAME) && I_de && !vs_rise_s && in_area_s;
  assign zc_s        = ZC_W'(col_r >> ZW_LOG2);
  assign zr_s        = ZR_W'(line_r >> ZH_LOG2);
  assign last_px_s   = (&col_r[ZW_LOG2-1:0]) && (&line_r[ZH_LOG2-1:0]);
  assign last_line_s = (&line_r[ZH_LOG2-1:0]) && (line_r < LW'(LINES));
  assign acc_old_s   = row_buf_r[s1_zc_r];
  assign emit_addr_s = ADDR_W'(s1_zr_r) * ADDR_W'(ZONES_H) + ADDR_W'(s1_zc_r);
  assign last_addr_s = (emit_addr_s == ADDR_W'(NZONES - 1));

  // zone accumulator update and the DATA_W gray value it yields
  always_comb begin
    acc_new_s = acc_old_s;
    if (s1_pix_r) begin
      if (s1_mode_r) begin
        acc_new_s = acc_old_s + SUM_W'(s1_p_r);
      end else if (SUM_W'(s1_p_r) > acc_old_s) begin
        acc_new_s = SUM_W'(s1_p_r);
      end else begin
        acc_new_s = acc_old_s;
      end
    end else begin
      acc_new_s = acc_old_s;
    end
    mean_s = acc_new_s >> SHIFT;
    if (s1_mode_r) begin
      gray8_s = DATA_W'(mean_s);
    end else begin
      gray8_s = acc_new_s[DATA_W-1:0];
    end
  end

  // frame-level FSM: frame start, completion and premature-vsync detection
  always_ff @(posedge I_pix_clk) begin
    if (!I_rst_n) begin
      state_r     <= S_WAIT_VS;
      busy_r      <= 1'b0;
      mode_r      <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      frame_err_r <= 1'b0;
      case (state_r)
        S_WAIT_VS, S_DONE: begin
          if (vs_rise_s) begin
            state_r <= S_FRAME;
            busy_r  <= 1'b1;
            mode_r  <= I_mode;
          end
        end
        S_FRAME: begin
          if (vs_rise_s) begin
            mode_r      <= I_mode;
            frame_err_r <= !done_s;
          end else if (done_s) begin
            state_r <= S_DONE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= S_WAIT_VS;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // pixel/line counters and flush of zones left unfinished by a short last line
  always_ff @(posedge I_pix_clk) begin
    if (!I_rst_n) begin
      vs_d_r     <= 1'b0;
      de_d_r     <= 1'b0;
      col_r      <= '0;
      line_r     <= '0;
      next_zc_r  <= '0;
      flush_r    <= 1'b0;
      flush_zc_r <= '0;
      flush_zr_r <= '0;
    end else begin
      vs_d_r <= I_vs;
      de_d_r <= I_de;
      if (vs_rise_s) begin
        col_r     <= '0;
        line_r    <= '0;
        next_zc_r <= '0;
        flush_r   <= 1'b0;
      end else begin
        if (!I_de) begin
          col_r <= '0;
        end else if (col_r != CW'(COLS)) begin
          col_r <= col_r + CW'(1);
        end
        if (de_fall_s && (line_r != LW'(LINES))) begin
          line_r <= line_r + LW'(1);
        end
        if (pix_ok_s && last_px_s) begin
          next_zc_r <= NZ_W'(zc_s) + NZ_W'(1);
        end else if (de_fall_s && last_line_s && (state_r == S_FRAME)) begin
          next_zc_r <= '0;
          if (next_zc_r < NZ_W'(ZONES_H)) begin
            flush_r    <= 1'b1;
            flush_zc_r <= ZC_W'(next_zc_r);
            flush_zr_r <= zr_s;
          end
        end else if (flush_r) begin
          if (flush_zc_r == ZC_W'(ZONES_H - 1)) begin
            flush_r <= 1'b0;
          end else begin
            flush_zc_r <= flush_zc_r + ZC_W'(1);
          end
        end
      end
    end
  end

  // stage 1: register pixel brightness with its zone coordinates and emit flag
  always_ff @(posedge I_pix_clk) begin
    if (!I_rst_n) begin
      s1_pix_r  <= 1'b0;
      s1_emit_r <= 1'b0;
      s1_mode_r <= 1'b0;
      s1_p_r    <= '0;
      s1_zc_r   <= '0;
      s1_zr_r   <= '0;
    end else begin
      s1_mode_r <= mode_r;
      s1_p_r    <= max3(I_data_r, I_data_g, I_data_b);
      if (flush_r && !vs_rise_s) begin
        s1_pix_r  <= 1'b0;
        s1_emit_r <= 1'b1;
        s1_zc_r   <= flush_zc_r;
        s1_zr_r   <= flush_zr_r;
      end else begin
        s1_pix_r  <= pix_ok_s;
        s1_emit_r <= pix_ok_s && last_px_s;
        s1_zc_r   <= zc_s;
        s1_zr_r   <= zr_s;
      end
    end
  end

  // row buffer: one accumulator per zone column, cleared once the zone emits
  always_ff @(posedge I_pix_clk) begin
    if (!I_rst_n || vs_rise_s) begin
      for (int i = 0; i < ZONES_H; i++) begin
        row_buf_r[i] <= '0;
      end
    end else if (s1_emit_r) begin
      row_buf_r[s1_zc_r] <= '0;
    end else if (s1_pix_r) begin
      row_buf_r[s1_zc_r] <= acc_new_s;
    end
  end

`ifdef ZONE_IIR_EN
  localparam int HA_W = (NZONES > 1) ? $clog2(NZONES) : 1;

  logic                s2_en_r, s2_last_r;
  logic [ADDR_W-1:0]   s2_addr_r;
  logic [GRAY_W-1:0]   s2_gray_r;
  logic [GRAY_W-1:0]   hist_r [NZONES];
  logic [GRAY_W-1:0]   prev_s, filt_out_s;
  logic [GRAY_W+1:0]   filt_s;

  assign prev_s     = hist_r[s2_addr_r[HA_W-1:0]];
  assign filt_s     = ({2'b00, prev_s} << 1) + {2'b00, prev_s} + {2'b00, s2_gray_r};
  assign filt_out_s = GRAY_W'(filt_s >> 2);
  assign done_s     = s2_en_r && s2_last_r;

  // stage 2: hold the unfiltered zone value for the history lookup
  always_ff @(posedge I_pix_clk) begin
    if (!I_rst_n) begin
      s2_en_r   <= 1'b0;
      s2_last_r <= 1'b0;
      s2_addr_r <= '0;
      s2_gray_r <= '0;
    end else begin
      s2_en_r   <= s1_emit_r;
      s2_last_r <= s1_emit_r && last_addr_s && !vs_rise_s;
      s2_addr_r <= emit_addr_s;
      s2_gray_r <= widen(gray8_s);
    end
  end

  // stage 3: temporal filter, history write-back and registered write port
  always_ff @(posedge I_pix_clk) begin
    if (!I_rst_n) begin
      for (int i = 0; i < NZONES; i++) begin
        hist_r[i] <= '0;
      end
      wr_en_r   <= 1'b0;
      sdbp_r    <= 1'b0;
      wr_addr_r <= '0;
      wr_data_r <= '0;
    end else begin
      wr_en_r   <= s2_en_r;
      sdbp_r    <= s2_en_r && (s2_addr_r == '0);
      wr_addr_r <= s2_en_r ? s2_addr_r : '0;
      wr_data_r <= s2_en_r ? filt_out_s : '0;
      if (s2_en_r) begin
        hist_r[s2_addr_r[HA_W-1:0]] <= filt_out_s;
      end
    end
  end
`else
  assign done_s = s1_emit_r && last_addr_s;

  // stage 2: registered write port carrying the finished zone value
  always_ff @(posedge I_pix_clk) begin
    if (!I_rst_n) begin
      wr_en_r   <= 1'b0;
      sdbp_r    <= 1'b0;
      wr_addr_r <= '0;
      wr_data_r <= '0;
    end else begin
      wr_en_r   <= s1_emit_r;
      sdbp_r    <= s1_emit_r && (emit_addr_s == '0);
      wr_addr_r <= s1_emit_r ? emit_addr_s : '0;
      wr_data_r <= s1_emit_r ? widen(gray8_s) : '0;
    end
  end
`endif

  assign O_sdbp      = sdbp_r;
  assign O_wr_en     = wr_en_r;
  assign O_wr_addr   = wr_addr_r;
  assign O_wr_data   = wr_data_r;
  assign O_frame_err = frame_err_r;
  assign O_busy      = busy_r;

endmodule

// File: tb/tb_zone_backlight_stat.sv
// Bench for zone_backlight_stat on an 8x4 frame of 2x2 zones (4x2 px each).
// Expected writes come from a zone-level reference model into a scoreboard queue.
module tb_zone_backlight_stat;
  localparam int AW = 10;
`ifdef ZONE_IIR_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          vs = 1'b0, de = 1'b0, mode = 1'b0;
  logic [7:0]    dr = 8'd0, dg = 8'd0, db = 8'd0;
  logic          sdbp, wr_en, frame_err, busy;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;

  zone_backlight_stat #(
    .DATA_W(8), .GRAY_W(16), .ZONES_H(2), .ZONES_V(2),
    .ZW_LOG2(2), .ZH_LOG2(1), .ADDR_W(AW)
  ) dut (
    .I_pix_clk(clk), .I_rst_n(rst_n), .I_vs(vs), .I_de(de),
    .I_data_r(dr), .I_data_g(dg), .I_data_b(db), .I_mode(mode),
    .O_sdbp(sdbp), .O_wr_en(wr_en), .O_wr_addr(wr_addr), .O_wr_data(wr_data),
    .O_frame_err(frame_err), .O_busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct { int addr; int data; int when; } wr_t;
  wr_t  exp_q[$];
  int   err_q[$];

  logic [7:0] pr[4][10], pg[4][10], pb[4][10];
  int         len[4];
  int         prev[4];
  bit         frame_open = 1'b0;
  bit         cur_mode = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // reference: reduce a whole zone from the frame arrays, widen 8->16 bits
  function automatic int zone_value(input int zr, input int zc, input bit md);
    int acc = 0;
    int p;
    for (int l = zr * 2; l < zr * 2 + 2; l++) begin
      for (int c = zc * 4; c < zc * 4 + 4; c++) begin
        if (c < len[l]) begin
          p = pr[l][c];
          if (pg[l][c] > p) p = pg[l][c];
          if (pb[l][c] > p) p = pb[l][c];
          if (md) acc += p;
          else if (p > acc) acc = p;
        end
      end
    end
    if (md) acc = acc / 8;
    return acc * 257;
  endfunction

  task automatic push_zone(input int zr, input int zc, input int when);
    wr_t e;
    int  a;
    int  v;
    a = zr * 2 + zc;
    v = zone_value(zr, zc, cur_mode);
`ifdef ZONE_IIR_EN
    v = (3 * prev[a] + v) / 4;
    prev[a] = v;
`endif
    e.addr = a;
    e.data = v;
    e.when = when;
    exp_q.push_back(e);
    if (a == 3) frame_open = 1'b0;
  endtask

  task automatic gen(input bit rnd_len);
    for (int l = 0; l < 4; l++) begin
      len[l] = rnd_len ? int'($urandom_range(5, 10)) : 8;
      for (int c = 0; c < 10; c++) begin
        pr[l][c] = 8'($urandom);
        pg[l][c] = 8'($urandom);
        pb[l][c] = 8'($urandom);
      end
    end
  endtask

  task automatic drive_line(input int l, input bit expect_wr);
    for (int c = 0; c < len[l]; c++) begin
      de = 1'b1;
      dr = pr[l][c];
      dg = pg[l][c];
      db = pb[l][c];
      if (expect_wr && (l % 2 == 1) && (c < 8) && (c % 4 == 3)) push_zone(l / 2, c / 4, cyc + LAT);
      step();
    end
    de = 1'b0;
    dr = 8'($urandom);
    dg = 8'($urandom);
    db = 8'($urandom);
    if (expect_wr && (l % 2 == 1)) begin
      for (int zc = 0; zc < 2; zc++) begin
        if (zc * 4 + 3 >= len[l]) push_zone(l / 2, zc, -1);
      end
    end
    repeat (6) step();
  endtask

  task automatic frame(input bit md, input int nlines);
    if (frame_open) err_q.push_back(cyc + 1);
    vs = 1'b1;
    mode = md;
    step();
    check("busy_after_vs", int'(busy), 1);
    frame_open = 1'b1;
    cur_mode = md;
    vs = 1'b0;
    mode = 1'($urandom);
    repeat (3) step();
    for (int l = 0; l < nlines; l++) drive_line(l, 1'b1);
    if (nlines == 4) check("busy_after_frame", int'(busy), 0);
  endtask

  // scoreboard monitor: every write and frame_err pulse is matched against the queues
  always @(negedge clk) begin
    wr_t e;
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr=%0d data=0x%0h, expected no write (cycle %0d)", wr_addr, wr_data, cyc);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", int'(wr_addr), e.addr);
        check("wr_data", int'(wr_data), e.data);
        check("sdbp_with_write", int'(sdbp), (e.addr == 0) ? 1 : 0);
        if (e.when >= 0) check("wr_latency_cycle", cyc, e.when);
      end
    end else if (sdbp === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL stray_sdbp: sdbp=1 without write, expected 0 (cycle %0d)", cyc);
    end
    if (frame_err === 1'b1) begin
      if (err_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame_err: got 1, expected 0 (cycle %0d)", cyc);
      end else begin
        check("frame_err_cycle", cyc, err_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    for (int i = 0; i < 4; i++) prev[i] = 0;
    // reset held 3 cycles with stimulus active
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vs = 1'($urandom);
      de = 1'($urandom);
      dr = 8'($urandom);
      dg = 8'($urandom);
      db = 8'($urandom);
      step();
      check("reset_outputs", int'({wr_en, sdbp, frame_err, busy, wr_addr, wr_data}), 0);
    end
    vs = 1'b0;
    de = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    // pixels without a vsync rise must not produce writes
    gen(1'b0);
    drive_line(1, 1'b0);
    drive_line(1, 1'b0);
    check("idle_busy", int'(busy), 0);

    // max mode: flat 0x10, one bright green pixel in zone 3
    gen(1'b0);
    for (int l = 0; l < 4; l++) begin
      for (int c = 0; c < 10; c++) begin
        pr[l][c] = 8'h10;
        pg[l][c] = 8'h10;
        pb[l][c] = 8'h10;
      end
    end
    pg[3][5] = 8'hF0;
    frame(1'b0, 4);

    // mean mode: zone 1 carries 0,2,..,14
    gen(1'b0);
    for (int k = 0; k < 8; k++) begin
      pr[k / 4][4 + k % 4] = 8'(2 * k);
      pg[k / 4][4 + k % 4] = 8'(2 * k);
      pb[k / 4][4 + k % 4] = 8'(2 * k);
    end
    frame(1'b1, 4);

    // short last line of zone row 0 (de falls after 5 pixels)
    gen(1'b0);
    len[1] = 5;
    frame(1'b1, 4);

    // vsync after two writes: frame_err, then a full frame restarting at addr 0
    gen(1'b0);
    frame(1'($urandom), 2);
    gen(1'b0);
    frame(1'b0, 4);

    // reset during line 2
    gen(1'b0);
    frame(1'b1, 2);
    for (int c = 0; c < 3; c++) begin
      de = 1'b1;
      dr = pr[2][c];
      dg = pg[2][c];
      db = pb[2][c];
      step();
    end
    rst_n = 1'b0;
    frame_open = 1'b0;
    for (int i = 0; i < 4; i++) prev[i] = 0;
    step();
    check("midframe_reset_outputs", int'({wr_en, sdbp, frame_err, busy, wr_addr, wr_data}), 0);
    step();
    rst_n = 1'b1;
    for (int c = 3; c < 8; c++) begin
      dr = pr[2][c];
      dg = pg[2][c];
      db = pb[2][c];
      step();
    end
    de = 1'b0;
    repeat (6) step();
    drive_line(3, 1'b0);
    check("busy_after_reset", int'(busy), 0);

    // randomized frames with random line lengths (short and over-long lines)
    for (int f = 0; f < 6; f++) begin
      gen(1'b1);
      frame(1'($urandom), 4);
    end

    repeat (20) step();
    check("write_queue_drained", exp_q.size(), 0);
    check("frame_err_queue_drained", err_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
